uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link; the receive-side counterpart of the transmit bit-rate generator. It synchronises the asynchronous `rx` line and detects the start bit. It runs its own bit-rate divider, which restarts on every start bit, so all samples land near bit centres. It delivers each byte with a one-cycle `rcv` strobe. It sits between the board RX pin and the echo/command logic.

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 99 +++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line into the receiver plus its byte/strobe/status outputs.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       busy;
  logic       ferr;
  modport master (input rx, output data, rcv, busy, ferr);
  modport slave (output rx, input data, rcv, busy, ferr);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-bit-aligned bit-rate divider.
// Define UART_RX_FERR_EN to flag bad stop bits on ferr and park in WAIT until the line idles.
module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.master bus
);
  localparam int HALF = BAUDRATE / 2;
  localparam int N = $clog2(BAUDRATE);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_RX_FERR_EN
    , WAIT
`endif
  } state_t;
  state_t       state;
  logic         rx_m, rx_s;
  logic [N-1:0] cnt;
  logic [2:0]   idx;
  logic [7:0]   shift;
  logic         tick;
  logic         counting;
  assign counting = state == START || state == DATA || state == STOP;
  // the start bit is sampled half a bit in so later samples land at bit centres
  assign tick = state == START ? cnt == N'(HALF - 1) : cnt == N'(BAUDRATE - 1);
`ifndef UART_RX_FERR_EN
  assign bus.ferr = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      bus.data <= '0;
      bus.rcv  <= 1'b0;
      bus.busy <= 1'b0;
`ifdef UART_RX_FERR_EN
      bus.ferr <= 1'b0;
`endif
    end else begin
      rx_m    <= bus.rx;
      rx_s    <= rx_m;
      bus.rcv <= 1'b0;
`ifdef UART_RX_FERR_EN
      bus.ferr <= 1'b0;
`endif
      cnt <= counting && !tick ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          bus.busy <= 1'b1;
        end
        START: if (tick) begin
          state    <= rx_s ? IDLE : DATA;
          bus.busy <= !rx_s;
          idx      <= '0;
        end
        DATA: if (tick) begin
          shift <= {rx_s, shift[7:1]};
          idx   <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
`ifdef UART_RX_FERR_EN
          if (rx_s) begin
            bus.data <= shift;
            bus.rcv  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            bus.ferr <= 1'b1;
            state    <= WAIT;
          end
`else
          bus.data <= shift;
          bus.rcv  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
`endif
        end
`ifdef UART_RX_FERR_EN
        WAIT: if (rx_s) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
`endif
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for two receivers (BAUDRATE 104 and 5).
module tb_uart_rx;
  localparam int BA = 104;
  localparam int BB = 5;
  typedef struct {
    bit         fe;
    logic [7:0] d;
    int         c;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  uart_rx_if ia();
  uart_rx_if ib();
  uart_rx #(.BAUDRATE(BA)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  uart_rx #(.BAUDRATE(BB)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input bit w, input logic r, input logic f, input logic [7:0] d);
    exp_t e;
    chk(w ? "b_rcv_and_ferr" : "a_rcv_and_ferr", {31'd0, r & f}, 32'd0);
    if ((w ? qb.size() : qa.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_output: got rcv=%b ferr=%b data=%02h expected no output (cycle %0d)",
               w ? "b" : "a", r, f, d, cyc);
    end else begin
      if (w) e = qb.pop_front();
      else e = qa.pop_front();
      chk(w ? "b_kind_ferr" : "a_kind_ferr", {31'd0, f}, {31'd0, e.fe});
      chk(w ? "b_data" : "a_data", {24'd0, d}, {24'd0, e.d});
      chk(w ? "b_cycle" : "a_cycle", cyc, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ia.rcv || ia.ferr) mon(1'b0, ia.rcv, ia.ferr, ia.data);
      if (ib.rcv || ib.ferr) mon(1'b1, ib.rcv, ib.ferr, ib.data);
    end
  end

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // model: byte arrives 2 sync/FSM edges + half a bit + 9 bits after the first low capture
  task automatic send(input bit w, input logic [7:0] b, input bit sb);
    int         bd = w ? BB : BA;
    logic [9:0] f = {sb, b, 1'b0};
    exp_t       e;
    e.c = cyc + 3 + bd / 2 + 9 * bd;
`ifdef UART_RX_FERR_EN
    e.fe = !sb;
`else
    e.fe = 1'b0;
`endif
    if (!e.fe) begin
      if (w) last_b = b;
      else last_a = b;
    end
    e.d = w ? last_b : last_a;
    if (w) qb.push_back(e);
    else qa.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (w) ib.rx = f[i];
      else ia.rx = f[i];
      idle(bd);
    end
  endtask

  initial begin
    int         p;
    int         bd;
    int         gap;
    logic [7:0] b;
    bit         sb;
    logic [9:0] f;
    ia.rx = 1'b1;
    ib.rx = 1'b1;
    idle(3);
    chk("reset_busy", {31'd0, ia.busy}, 32'd0);
    chk("reset_data", {24'd0, ia.data}, 32'd0);
    chk("reset_rcv", {31'd0, ia.rcv}, 32'd0);
    chk("reset_b_busy", {31'd0, ib.busy}, 32'd0);
    rst = 1'b0;
    idle(3);
    p = cyc;
    fork
      send(1'b0, 8'h55, 1'b1);
      begin
        at(p + 2);
        chk("busy_before_start", {31'd0, ia.busy}, 32'd0);
        at(p + 3);
        chk("busy_rise", {31'd0, ia.busy}, 32'd1);
        at(p + 990);
        chk("busy_last", {31'd0, ia.busy}, 32'd1);
        at(p + 991);
        chk("busy_fall", {31'd0, ia.busy}, 32'd0);
      end
    join
    chk("data_hold_55", {24'd0, ia.data}, {24'd0, last_a});
    send(1'b0, 8'hA3, 1'b1);
    send(1'b0, 8'h0F, 1'b1);
    p = cyc;
    ia.rx = 1'b0;
    idle(20);
    ia.rx = 1'b1;
    at(p + 54);
    chk("glitch_busy_high", {31'd0, ia.busy}, 32'd1);
    at(p + 55);
    chk("glitch_busy_low", {31'd0, ia.busy}, 32'd0);
    idle(100);
    send(1'b0, 8'h81, 1'b0);
`ifdef UART_RX_FERR_EN
    idle(300);
    chk("ferr_wait_busy", {31'd0, ia.busy}, 32'd1);
`endif
    ia.rx = 1'b1;
    idle(BA);
    chk("ferr_data", {24'd0, ia.data}, {24'd0, last_a});
    f = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ia.rx = f[i];
      idle(BA);
    end
    ia.rx = f[5];
    idle(BA / 2);
    rst = 1'b1;
    ia.rx = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, ia.busy}, 32'd0);
    chk("midrst_data", {24'd0, ia.data}, 32'd0);
    last_a = 8'h00;
    last_b = 8'h00;
    idle(1);
    rst = 1'b0;
    idle(2 * BA);
    send(1'b0, 8'h3C, 1'b1);
    send(1'b1, 8'hFF, 1'b1);
    send(1'b1, 8'h00, 1'b1);
    idle(BB);
    for (int n = 0; n < 24; n++) begin
      bit w = n >= 12;
      bd = w ? BB : BA;
      b = 8'($urandom);
      sb = $urandom_range(0, 4) != 0;
      send(w, b, sb);
      if (w) ib.rx = 1'b1;
      else ia.rx = 1'b1;
      gap = $urandom_range(0, 3 * bd) + (sb ? 0 : bd);
      if (gap > 0) idle(gap);
    end
    idle(20);
    chk("a_queue_empty", qa.size(), 32'd0);
    chk("b_queue_empty", qb.size(), 32'd0);
    chk("a_final_data", {24'd0, ia.data}, {24'd0, last_a});
    chk("b_final_data", {24'd0, ib.data}, {24'd0, last_b});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
